// File: rtl/matmul_tile_sequencer_if.sv
// Handshake and BRAM/core control bundle for matmul_tile_sequencer.
// master: the sequencer itself; slave: the environment (core, BRAMs, host).
interface matmul_tile_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);
  // host handshake
  logic                  start;
  logic                  abort;
  logic                  ready;
  logic                  busy;
  logic                  done;
  // BRAM port-B read side
  logic                  in_enb;
  logic [ADDR_WIDTH-1:0] in_addrb;
  logic                  wb_enb;
  logic [ADDR_WIDTH-1:0] wb_addrb;
  // systolic core control/status
  logic                  core_en;
  logic                  core_rst_acc;
  logic                  systolic_finish;
  logic                  accumulator_done;
  // tile progress
  logic                  tile_valid;
  logic [15:0]           tile_row;
  logic [15:0]           tile_col;
  // performance counters (zero unless MATMUL_SEQ_PERF_EN)
  logic [31:0]           perf_cycles;
  logic [31:0]           perf_stall;

  modport master (
    input  start, abort, systolic_finish, accumulator_done,
    output ready, busy, done,
    output in_enb, in_addrb, wb_enb, wb_addrb,
    output core_en, core_rst_acc,
    output tile_valid, tile_row, tile_col,
    output perf_cycles, perf_stall
  );

  modport slave (
    output start, abort, systolic_finish, accumulator_done,
    input  ready, busy, done,
    input  in_enb, in_addrb, wb_enb, wb_addrb,
    input  core_en, core_rst_acc,
    input  tile_valid, tile_row, tile_col,
    input  perf_cycles, perf_stall
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Sequences one C = I x W^T multiply on the systolic core: output tiles are
// walked row-major, and for each tile the inner-dimension steps are fetched
// from the input/weight BRAMs (port B) and fed to the core.
// Optional busy/stall performance counters: define MATMUL_SEQ_PERF_EN.
module matmul_tile_sequencer #(
  parameter int BLOCK_SIZE        = 2,
  parameter int INNER_DIMENSION   = 4,
  parameter int I_OUTER_DIMENSION = 6,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH        = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  matmul_tile_sequencer_if.master       bus
);

  localparam int K_STEPS   = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ROW_TILES = I_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int COL_TILES = W_OUTER_DIMENSION / BLOCK_SIZE;

  localparam logic [15:0] K_LAST   = 16'(K_STEPS - 1);
  localparam logic [15:0] ROW_LAST = 16'(ROW_TILES - 1);
  localparam logic [15:0] COL_LAST = 16'(COL_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_COMPUTE,
    S_WAIT_ACC,
    S_NEXT_TILE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           k_q, k_d;
  logic [15:0]           row_q, row_d;
  logic [15:0]           col_q, col_d;
  logic                  acc_seen_q, acc_seen_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                  busy_w;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_seen_q <= 1'b0;
      in_addr_q  <= '0;
      wb_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_seen_q <= acc_seen_d;
      in_addr_q  <= in_addr_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  // Next-state, tile/step counters and registered BRAM addresses
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_seen_d = acc_seen_q;
    in_addr_d  = in_addr_q;
    wb_addr_d  = wb_addr_q;

    if (bus.abort) begin
      state_d    = S_IDLE;
      k_d        = '0;
      row_d      = '0;
      col_d      = '0;
      acc_seen_d = 1'b0;
      in_addr_d  = '0;
      wb_addr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_CLR;
            k_d        = '0;
            row_d      = '0;
            col_d      = '0;
            acc_seen_d = 1'b0;
          end
        end
        S_CLR: begin
          state_d    = S_FETCH;
          acc_seen_d = 1'b0;
        end
        S_FETCH: begin
          state_d = S_COMPUTE;
        end
        S_COMPUTE: begin
          // an early accumulator_done is remembered so WAIT_ACC can exit at once
          if (bus.accumulator_done) begin
            acc_seen_d = 1'b1;
          end
          if (bus.systolic_finish) begin
            if (k_q < K_LAST) begin
              k_d     = k_q + 16'd1;
              state_d = S_FETCH;
            end else begin
              k_d     = '0;
              state_d = S_WAIT_ACC;
            end
          end
        end
        S_WAIT_ACC: begin
          if (bus.accumulator_done || acc_seen_q) begin
            state_d    = S_NEXT_TILE;
            acc_seen_d = 1'b0;
          end
        end
        S_NEXT_TILE: begin
          if (col_q < COL_LAST) begin
            col_d   = col_q + 16'd1;
            state_d = S_CLR;
          end else if (row_q < ROW_LAST) begin
            col_d   = '0;
            row_d   = row_q + 16'd1;
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Addresses are loaded on entry to FETCH from the next-cycle counters, so
    // they are registered during FETCH and held stable through COMPUTE.
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      in_addr_d = ADDR_WIDTH'(32'(k_d) + 32'(K_STEPS) * 32'(row_d));
      wb_addr_d = ADDR_WIDTH'(32'(k_d) + 32'(K_STEPS) * 32'(col_d));
    end
  end

  assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

  // Moore outputs decoded from the state register
  assign bus.ready        = (state_q == S_IDLE);
  assign bus.busy         = busy_w;
  assign bus.done         = (state_q == S_DONE);
  assign bus.in_enb       = (state_q == S_FETCH);
  assign bus.wb_enb       = (state_q == S_FETCH);
  assign bus.in_addrb     = in_addr_q;
  assign bus.wb_addrb     = wb_addr_q;
  assign bus.core_en      = (state_q == S_COMPUTE);
  assign bus.core_rst_acc = (state_q == S_CLR);
  assign bus.tile_valid   = (state_q == S_NEXT_TILE);
  assign bus.tile_row     = row_q;
  assign bus.tile_col     = col_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q,  perf_stall_d;

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  // Saturating busy/stall counts, cleared when a new multiply is accepted
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == S_IDLE && bus.start && !bus.abort) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy_w && perf_cycles_q != '1) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if (state_q == S_WAIT_ACC && perf_stall_q != '1) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stall  = perf_stall_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_stall  = '0;
`endif

  // Protocol properties of the sequencer
  a_abort_idle : assert property (@(posedge clk) disable iff (!rst_n)
    bus.abort |=> (state_q == S_IDLE));
  a_start_clr : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_IDLE && bus.start && !bus.abort) |=> (state_q == S_CLR));
  a_tile_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    bus.tile_valid |=> !bus.tile_valid);
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done);

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer with a small reactive core model:
// systolic_finish 3 cycles after core_en rises, accumulator_done a chosen lag
// after the final finish of each tile.
module tb_matmul_tile_sequencer;

  localparam int BS        = 2;
  localparam int INNER     = 4;
  localparam int IOUT      = 6;
  localparam int WOUT      = 6;
  localparam int AW        = 12;
  localparam int K_STEPS   = INNER / BS;
  localparam int ROW_TILES = IOUT / BS;
  localparam int COL_TILES = WOUT / BS;
  localparam int N_TILES   = ROW_TILES * COL_TILES;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  matmul_tile_sequencer_if #(.ADDR_WIDTH(AW)) dut_if ();

  matmul_tile_sequencer #(
    .BLOCK_SIZE       (BS),
    .INNER_DIMENSION  (INNER),
    .I_OUTER_DIMENSION(IOUT),
    .W_OUTER_DIMENSION(WOUT),
    .ADDR_WIDTH       (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dut_if.start            = 1'b0;
    dut_if.abort            = 1'b0;
    dut_if.systolic_finish  = 1'b0;
    dut_if.accumulator_done = 1'b0;
  endtask

  // One multiply with the core model. lag: accumulator_done delay after the
  // final finish; stray: re-pulse start during COMPUTE; abort_tile: abort in
  // the WAIT_ACC of that tile (-1 none); rst_fetch: async reset during that
  // FETCH (-1 none).
  task automatic run_mult(input int lag, input bit stray, input int abort_tile,
                          input int rst_fetch, input string tag);
    int fetches, tiles, dones, clrs, en_cnt, fin_cnt, cycles, acc_cd, gap, exp_gap, t, kk;
    bit gap_on, abort_next, abort_sent, stopped, finished;
    logic [AW-1:0] exp_in, exp_wb;
    fetches = 0; tiles = 0; dones = 0; clrs = 0; en_cnt = 0; fin_cnt = 0;
    cycles = 0; acc_cd = -1; gap = 0; gap_on = 0;
    abort_next = 0; abort_sent = 0; stopped = 0; finished = 0;
    exp_gap = (lag == 0) ? 2 : lag + 1;

    clear_inputs();
    dut_if.start = 1'b1;
    cycle();
    dut_if.start = 1'b0;

    while (!finished && cycles < 3000) begin
      cycles++;
      if (gap_on) gap++;
      if (abort_sent) begin
        checks++;
        if ({dut_if.ready, dut_if.busy, dut_if.core_en, dut_if.in_enb, dut_if.tile_valid} !== 5'b10000 ||
            dut_if.tile_row !== 16'd0 || dut_if.tile_col !== 16'd0) begin
          failures++;
          $display("FAIL %s abort_to_idle got ready=%0b busy=%0b core_en=%0b in_enb=%0b row=%0d col=%0d want 1 0 0 0 0 0",
                   tag, dut_if.ready, dut_if.busy, dut_if.core_en, dut_if.in_enb, dut_if.tile_row, dut_if.tile_col);
        end
        finished = 1; stopped = 1;
      end else begin
        if (dut_if.in_enb) begin
          t      = fetches / K_STEPS;
          kk     = fetches % K_STEPS;
          exp_in = AW'(kk + K_STEPS * (t / COL_TILES));
          exp_wb = AW'(kk + K_STEPS * (t % COL_TILES));
          checks++;
          if (dut_if.in_addrb !== exp_in) begin
            failures++;
            $display("FAIL %s in_addrb fetch=%0d got=%0d want=%0d", tag, fetches, dut_if.in_addrb, exp_in);
          end
          checks++;
          if (dut_if.wb_addrb !== exp_wb) begin
            failures++;
            $display("FAIL %s wb_addrb fetch=%0d got=%0d want=%0d", tag, fetches, dut_if.wb_addrb, exp_wb);
          end
          checks++;
          if ({dut_if.wb_enb, dut_if.core_en} !== 2'b10) begin
            failures++;
            $display("FAIL %s fetch_enables fetch=%0d got wb_enb=%0b core_en=%0b want 1 0",
                     tag, fetches, dut_if.wb_enb, dut_if.core_en);
          end
          if (fetches == rst_fetch) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if ({dut_if.in_enb, dut_if.wb_enb, dut_if.core_en, dut_if.ready} !== 4'b0001) begin
              failures++;
              $display("FAIL %s async_reset got in_enb=%0b wb_enb=%0b core_en=%0b ready=%0b want 0 0 0 1",
                       tag, dut_if.in_enb, dut_if.wb_enb, dut_if.core_en, dut_if.ready);
            end
            #2;
            rst_n = 1'b1;
            finished = 1; stopped = 1;
          end
          fetches++;
        end
        if (!finished) begin
          if (dut_if.core_rst_acc) clrs++;
          if (dut_if.tile_valid) begin
            checks++;
            if (dut_if.tile_row !== 16'(tiles / COL_TILES) || dut_if.tile_col !== 16'(tiles % COL_TILES)) begin
              failures++;
              $display("FAIL %s tile_order n=%0d got=(%0d,%0d) want=(%0d,%0d)", tag, tiles,
                       dut_if.tile_row, dut_if.tile_col, tiles / COL_TILES, tiles % COL_TILES);
            end
            checks++;
            if (!gap_on || gap != exp_gap) begin
              failures++;
              $display("FAIL %s tile_latency n=%0d got=%0d want=%0d", tag, tiles, gap, exp_gap);
            end
            gap_on = 0;
            tiles++;
          end
          if (dut_if.done) begin
            dones++;
            finished = 1;
          end
        end
      end

      clear_inputs();
      if (!finished) begin
        if (abort_next) begin
          dut_if.abort = 1'b1;
          abort_next   = 0;
          abort_sent   = 1;
        end
        if (dut_if.core_en) en_cnt++;
        else en_cnt = 0;
        if (en_cnt == 3) begin
          dut_if.systolic_finish = 1'b1;
          fin_cnt++;
          if (fin_cnt % K_STEPS == 0) begin
            acc_cd = lag; gap = 0; gap_on = 1;
            if (fin_cnt / K_STEPS - 1 == abort_tile) abort_next = 1;
          end
        end else if (stray && dut_if.core_en) begin
          dut_if.start = 1'b1;
        end
        if (acc_cd == 0) dut_if.accumulator_done = 1'b1;
        if (acc_cd >= 0) acc_cd--;
        cycle();
      end
    end
    clear_inputs();

    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d cycles want=done", tag, cycles);
    end else if (!stopped) begin
      checks++;
      if (fetches != K_STEPS * N_TILES || tiles != N_TILES || dones != 1 || clrs != N_TILES) begin
        failures++;
        $display("FAIL %s totals got fetch=%0d tiles=%0d done=%0d clr=%0d want %0d %0d 1 %0d",
                 tag, fetches, tiles, dones, clrs, K_STEPS * N_TILES, N_TILES, N_TILES);
      end
      cycle();
      checks++;
      if ({dut_if.ready, dut_if.busy, dut_if.done} !== 3'b100) begin
        failures++;
        $display("FAIL %s return_idle got ready=%0b busy=%0b done=%0b want 1 0 0",
                 tag, dut_if.ready, dut_if.busy, dut_if.done);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({dut_if.ready, dut_if.busy, dut_if.done, dut_if.in_enb, dut_if.wb_enb,
         dut_if.core_en, dut_if.core_rst_acc, dut_if.tile_valid} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=10000000",
               {dut_if.ready, dut_if.busy, dut_if.done, dut_if.in_enb, dut_if.wb_enb,
                dut_if.core_en, dut_if.core_rst_acc, dut_if.tile_valid});
    end
    checks++;
    if (dut_if.in_addrb !== '0 || dut_if.wb_addrb !== '0 || dut_if.tile_row !== 16'd0 ||
        dut_if.tile_col !== 16'd0 || dut_if.perf_cycles !== 32'd0 || dut_if.perf_stall !== 32'd0) begin
      failures++;
      $display("FAIL reset_values got in=%0d wb=%0d row=%0d col=%0d pc=%0d ps=%0d want all 0",
               dut_if.in_addrb, dut_if.wb_addrb, dut_if.tile_row, dut_if.tile_col,
               dut_if.perf_cycles, dut_if.perf_stall);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_full_run();
    run_mult(2, 1'b0, -1, -1, "full_run");
`ifdef MATMUL_SEQ_PERF_EN
    checks++;
    if (dut_if.perf_stall !== 32'd18) begin
      failures++;
      $display("FAIL perf_stall got=%0d want=18", dut_if.perf_stall);
    end
    checks++;
    if (dut_if.perf_cycles === 32'd0) begin
      failures++;
      $display("FAIL perf_cycles got=0 want=nonzero");
    end
`else
    checks++;
    if (dut_if.perf_cycles !== 32'd0 || dut_if.perf_stall !== 32'd0) begin
      failures++;
      $display("FAIL perf_tied got pc=%0d ps=%0d want 0 0", dut_if.perf_cycles, dut_if.perf_stall);
    end
`endif
  endtask

  task automatic test_coincident_acc();
    run_mult(0, 1'b0, -1, -1, "coincident");
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 3; i++) begin
      dut_if.systolic_finish  = 1'b1;
      dut_if.accumulator_done = 1'b1;
      cycle();
      checks++;
      if ({dut_if.ready, dut_if.busy, dut_if.in_enb, dut_if.core_en, dut_if.tile_valid} !== 5'b10000) begin
        failures++;
        $display("FAIL stray_idle got ready=%0b busy=%0b in_enb=%0b core_en=%0b tv=%0b want 1 0 0 0 0",
                 dut_if.ready, dut_if.busy, dut_if.in_enb, dut_if.core_en, dut_if.tile_valid);
      end
    end
    clear_inputs();
    run_mult(2, 1'b1, -1, -1, "stray_start");
  endtask

  task automatic test_abort();
    run_mult(2, 1'b0, 4, -1, "abort");
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (dut_if.done !== 1'b0 || dut_if.ready !== 1'b1) begin
        failures++;
        $display("FAIL abort_quiet got done=%0b ready=%0b want 0 1", dut_if.done, dut_if.ready);
      end
    end
    run_mult(2, 1'b0, -1, -1, "after_abort");
  endtask

  task automatic test_async_reset();
    run_mult(2, 1'b0, -1, 2, "reset_fetch");
    run_mult(2, 1'b0, -1, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_coincident_acc();
    test_ignored_inputs();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
